// File: rtl/vend_ctrl_n.sv
// Parametrised vending controller: credits coins, sells one of N_DRINKS drinks,
// and pays change or refunds greedily, largest coin first, over a ready/valid handshake.
module vend_ctrl_n #(
  parameter int                          N_DRINKS    = 4,
  parameter int                          SUM_W       = 8,
  parameter logic [4*SUM_W-1:0]          COIN_VALUES = {8'd10, 8'd5, 8'd2, 8'd1},
  parameter logic [N_DRINKS*SUM_W-1:0]   PRICES      = {8'd12, 8'd8, 8'd5, 8'd3},
  parameter int                          MAX_SUM     = 50,
  parameter int                          TIMEOUT_CYC = 30,
  parameter int                          VEND_CYC    = 2,
  localparam int                         OP_W        = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                insert,
  input  logic [1:0]          coin_val,
  input  logic                drink_req,
  input  logic [OP_W-1:0]     drink_op,
  input  logic                cancel_flag,
  input  logic                change_ready,
  output logic                hold_ind,
  output logic [N_DRINKS-1:0] drink_ind,
  output logic                coin_reject,
  output logic                price_short,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                charge_ind,
  output logic [SUM_W-1:0]    coin_sum
);

  // state   | meaning
  // IDLE    | no credit, waiting for the first coin
  // COLLECT | accumulating credit, idle timer running
  // VEND    | drink indicator held for VEND_CYC cycles
  // CHANGE  | paying out remaining credit coin by coin
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  localparam int TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int VCNT_W = (VEND_CYC > 1) ? $clog2(VEND_CYC) : 1;

  state_t                state_q, state_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [VCNT_W-1:0]     vcnt_q, vcnt_d;
  logic [N_DRINKS-1:0]   drink_q, drink_d;
  logic                  reject_q, reject_d;
  logic                  short_q, short_d;
  logic                  valid_q, valid_d;
  logic [1:0]            coin_q, coin_d;
  logic                  hold_q, hold_d;
  logic                  charge_q, charge_d;

  logic                  go_change;
  logic                  op_ok;
  logic [SUM_W-1:0]      price;
  logic [N_DRINKS-1:0]   op_onehot;
  logic [SUM_W:0]        ins_sum;

  function automatic logic [SUM_W-1:0] coin_value(input logic [1:0] idx);
    coin_value = '0;
    for (int i = 0; i < 4; i++)
      if (idx == 2'(i)) coin_value = COIN_VALUES[i*SUM_W +: SUM_W];
  endfunction

  // Ascending scan leaves the highest index whose value still fits.
  function automatic logic [1:0] greedy(input logic [SUM_W-1:0] s);
    greedy = 2'd0;
    for (int i = 0; i < 4; i++)
      if (COIN_VALUES[i*SUM_W +: SUM_W] <= s) greedy = 2'(i);
  endfunction

  always_comb begin
    op_ok     = 1'b0;
    price     = '0;
    op_onehot = '0;
    for (int i = 0; i < N_DRINKS; i++) begin
      if (int'(drink_op) == i) begin
        op_ok        = 1'b1;
        price        = PRICES[i*SUM_W +: SUM_W];
        op_onehot[i] = 1'b1;
      end
    end
    ins_sum = {1'b0, sum_q} + {1'b0, coin_value(coin_val)};
  end

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    timer_d   = timer_q;
    vcnt_d    = vcnt_q;
    drink_d   = drink_q;
    reject_d  = 1'b0;
    short_d   = 1'b0;
    valid_d   = valid_q;
    coin_d    = coin_q;
    hold_d    = hold_q;
    charge_d  = charge_q;
    go_change = 1'b0;

    case (state_q)
      IDLE: begin
        if (insert) begin
          sum_d   = coin_value(coin_val);
          timer_d = TMR_W'(TIMEOUT_CYC - 1);
          state_d = COLLECT;
        end else if (drink_req) begin
          short_d = 1'b1;
        end
      end
      COLLECT: begin
        if (insert) begin
          timer_d = TMR_W'(TIMEOUT_CYC - 1);
          if (ins_sum > (SUM_W+1)'(MAX_SUM)) reject_d = 1'b1;
          else                               sum_d    = ins_sum[SUM_W-1:0];
        end
        if (cancel_flag) begin
          go_change = 1'b1;
        end else if (!insert) begin
          if (drink_req && op_ok && sum_q >= price) begin
            sum_d   = sum_q - price;
            drink_d = op_onehot;
            vcnt_d  = VCNT_W'(VEND_CYC - 1);
            hold_d  = 1'b1;
            state_d = VEND;
          end else begin
            if (drink_req && op_ok) short_d = 1'b1;
            if (timer_q == '0) go_change = 1'b1;
            else               timer_d   = timer_q - 1'b1;
          end
        end
      end
      VEND: begin
        if (vcnt_q == '0) begin
          drink_d   = '0;
          go_change = 1'b1;
        end else begin
          vcnt_d = vcnt_q - 1'b1;
        end
      end
      CHANGE: begin
        if (valid_q && change_ready) begin
          sum_d     = sum_q - coin_value(coin_q);
          go_change = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared exit into CHANGE; an empty credit goes straight back to IDLE.
    if (go_change) begin
      if (sum_d == '0) begin
        state_d  = IDLE;
        hold_d   = 1'b0;
        charge_d = 1'b0;
        valid_d  = 1'b0;
      end else begin
        state_d  = CHANGE;
        hold_d   = 1'b1;
        charge_d = 1'b1;
        valid_d  = 1'b1;
        coin_d   = greedy(sum_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      timer_q  <= '0;
      vcnt_q   <= '0;
      drink_q  <= '0;
      reject_q <= 1'b0;
      short_q  <= 1'b0;
      valid_q  <= 1'b0;
      coin_q   <= 2'd0;
      hold_q   <= 1'b0;
      charge_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      timer_q  <= timer_d;
      vcnt_q   <= vcnt_d;
      drink_q  <= drink_d;
      reject_q <= reject_d;
      short_q  <= short_d;
      valid_q  <= valid_d;
      coin_q   <= coin_d;
      hold_q   <= hold_d;
      charge_q <= charge_d;
    end
  end

  assign hold_ind     = hold_q;
  assign drink_ind    = drink_q;
  assign coin_reject  = reject_q;
  assign price_short  = short_q;
  assign change_valid = valid_q;
  assign change_coin  = coin_q;
  assign charge_ind   = charge_q;
  assign coin_sum     = sum_q;

endmodule

// File: tb/tb_vend_ctrl_n.sv
// Directed bench for vend_ctrl_n with default parameters: coins {1,2,5,10}, prices {3,5,8,12}.
module tb_vend_ctrl_n;
  logic       clk = 1'b0;
  logic       rst, insert, drink_req, cancel_flag, change_ready;
  logic [1:0] coin_val, drink_op;
  logic       hold_ind, coin_reject, price_short, change_valid, charge_ind;
  logic [3:0] drink_ind;
  logic [1:0] change_coin;
  logic [7:0] coin_sum;

  int vec_cnt = 0;
  int err_cnt = 0;

  vend_ctrl_n dut (
    .clk(clk), .rst(rst), .insert(insert), .coin_val(coin_val),
    .drink_req(drink_req), .drink_op(drink_op), .cancel_flag(cancel_flag),
    .change_ready(change_ready), .hold_ind(hold_ind), .drink_ind(drink_ind),
    .coin_reject(coin_reject), .price_short(price_short), .change_valid(change_valid),
    .change_coin(change_coin), .charge_ind(charge_ind), .coin_sum(coin_sum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] idx);
    insert = 1'b1; coin_val = idx;
    tick();
    insert = 1'b0;
  endtask

  // Cancel then accept every offered coin until the controller goes idle.
  task automatic drain(input string tag);
    int n;
    cancel_flag = 1'b1;
    tick();
    cancel_flag = 1'b0;
    change_ready = 1'b1;
    n = 0;
    while (hold_ind && n < 20) begin tick(); n++; end
    change_ready = 1'b0;
    vec_cnt++;
    if (hold_ind !== 1'b0 || coin_sum !== 8'd0) begin
      err_cnt++;
      $display("FAIL %s drain: hold=%0b sum=%0d want hold=0 sum=0", tag, hold_ind, coin_sum);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; insert = 0; coin_val = 0; drink_req = 0; drink_op = 0;
    cancel_flag = 0; change_ready = 0;
    tick(); tick();
    rst = 1'b0;
    vec_cnt++;
    if ({hold_ind, drink_ind, coin_reject, price_short, change_valid, charge_ind, coin_sum} !== 17'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h want 0",
               {hold_ind, drink_ind, coin_reject, price_short, change_valid, charge_ind, coin_sum});
    end
    drink_req = 1'b1; drink_op = 2'd0;
    tick();
    drink_req = 1'b0;
    vec_cnt++;
    if (price_short !== 1'b1 || coin_sum !== 8'd0 || hold_ind !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_short: short=%0b sum=%0d hold=%0b want 1,0,0", price_short, coin_sum, hold_ind);
    end
  endtask

  task automatic test_vend();
    change_ready = 1'b1;
    coin(2'd2);
    vec_cnt++;
    if (coin_sum !== 8'd5) begin err_cnt++; $display("FAIL vend_sum5: got %0d want 5", coin_sum); end
    coin(2'd1);
    vec_cnt++;
    if (coin_sum !== 8'd7) begin err_cnt++; $display("FAIL vend_sum7: got %0d want 7", coin_sum); end
    drink_req = 1'b1; drink_op = 2'd1;
    tick();
    drink_req = 1'b0;
    vec_cnt++;
    if (drink_ind !== 4'b0010 || coin_sum !== 8'd2 || hold_ind !== 1'b1) begin
      err_cnt++;
      $display("FAIL vend_c1: drink=%b sum=%0d hold=%0b want 0010,2,1", drink_ind, coin_sum, hold_ind);
    end
    tick();
    vec_cnt++;
    if (drink_ind !== 4'b0010) begin err_cnt++; $display("FAIL vend_c2: drink=%b want 0010", drink_ind); end
    tick();
    vec_cnt++;
    if (drink_ind !== 4'b0000 || charge_ind !== 1'b1 || change_valid !== 1'b1 || change_coin !== 2'd1) begin
      err_cnt++;
      $display("FAIL vend_change: drink=%b charge=%0b valid=%0b coin=%0d want 0000,1,1,1",
               drink_ind, charge_ind, change_valid, change_coin);
    end
    tick();
    vec_cnt++;
    if (coin_sum !== 8'd0 || change_valid !== 1'b0 || hold_ind !== 1'b0 || charge_ind !== 1'b0) begin
      err_cnt++;
      $display("FAIL vend_idle: sum=%0d valid=%0b hold=%0b charge=%0b want 0,0,0,0",
               coin_sum, change_valid, hold_ind, charge_ind);
    end
    change_ready = 1'b0;
  endtask

  task automatic test_price_short();
    coin(2'd2);
    coin(2'd1);
    drink_req = 1'b1; drink_op = 2'd3;
    tick();
    drink_req = 1'b0;
    vec_cnt++;
    if (price_short !== 1'b1 || coin_sum !== 8'd7 || drink_ind !== 4'd0 || hold_ind !== 1'b0) begin
      err_cnt++;
      $display("FAIL short_pulse: short=%0b sum=%0d drink=%b hold=%0b want 1,7,0000,0",
               price_short, coin_sum, drink_ind, hold_ind);
    end
    tick();
    vec_cnt++;
    if (price_short !== 1'b0) begin err_cnt++; $display("FAIL short_single: got %0b want 0", price_short); end
    drain("short");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) coin(2'd3);
    vec_cnt++;
    if (coin_sum !== 8'd50) begin err_cnt++; $display("FAIL ovf_sum50: got %0d want 50", coin_sum); end
    coin(2'd0);
    vec_cnt++;
    if (coin_reject !== 1'b1 || coin_sum !== 8'd50) begin
      err_cnt++;
      $display("FAIL ovf_reject: rej=%0b sum=%0d want 1,50", coin_reject, coin_sum);
    end
    tick();
    vec_cnt++;
    if (coin_reject !== 1'b0) begin err_cnt++; $display("FAIL ovf_single: got %0b want 0", coin_reject); end
    insert = 1'b1; coin_val = 2'd0; drink_req = 1'b1; drink_op = 2'd0;
    tick();
    insert = 1'b0; drink_req = 1'b0;
    vec_cnt++;
    if (coin_reject !== 1'b1 || drink_ind !== 4'd0 || coin_sum !== 8'd50 || hold_ind !== 1'b0) begin
      err_cnt++;
      $display("FAIL ovf_drop: rej=%0b drink=%b sum=%0d hold=%0b want 1,0000,50,0",
               coin_reject, drink_ind, coin_sum, hold_ind);
    end
    drain("ovf");
  endtask

  task automatic test_change_stall();
    logic [1:0] exp_coin [3];
    logic [7:0] exp_sum  [3];
    exp_coin = '{2'd1, 2'd0, 2'd0};
    exp_sum  = '{8'd3, 8'd1, 8'd0};
    coin(2'd2); coin(2'd1); coin(2'd0);
    cancel_flag = 1'b1;
    tick();
    cancel_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (change_valid !== 1'b1 || change_coin !== 2'd2 || coin_sum !== 8'd8 || charge_ind !== 1'b1) begin
        err_cnt++;
        $display("FAIL stall_%0d: valid=%0b coin=%0d sum=%0d charge=%0b want 1,2,8,1",
                 i, change_valid, change_coin, coin_sum, charge_ind);
      end
      if (i < 3) tick();
    end
    change_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (coin_sum !== exp_sum[i] || (i < 2 && (change_coin !== exp_coin[i] || charge_ind !== 1'b1
          || change_valid !== 1'b1)) || (i == 2 && (change_valid !== 1'b0 || hold_ind !== 1'b0))) begin
        err_cnt++;
        $display("FAIL payout_%0d: sum=%0d coin=%0d valid=%0b hold=%0b want sum=%0d coin=%0d",
                 i, coin_sum, change_coin, change_valid, hold_ind, exp_sum[i], exp_coin[i]);
      end
    end
    change_ready = 1'b0;
  endtask

  task automatic test_timeout();
    coin(2'd0);
    for (int i = 0; i < 29; i++) tick();
    vec_cnt++;
    if (charge_ind !== 1'b0 || hold_ind !== 1'b0) begin
      err_cnt++;
      $display("FAIL timeout_early: charge=%0b hold=%0b want 0,0", charge_ind, hold_ind);
    end
    tick();
    vec_cnt++;
    if (charge_ind !== 1'b1 || change_valid !== 1'b1 || change_coin !== 2'd0 || coin_sum !== 8'd1) begin
      err_cnt++;
      $display("FAIL timeout_fire: charge=%0b valid=%0b coin=%0d sum=%0d want 1,1,0,1",
               charge_ind, change_valid, change_coin, coin_sum);
    end
    coin(2'd3);
    vec_cnt++;
    if (coin_sum !== 8'd1) begin err_cnt++; $display("FAIL change_ignore: sum=%0d want 1", coin_sum); end
    change_ready = 1'b1;
    coin(2'd3);
    change_ready = 1'b0;
    vec_cnt++;
    if (coin_sum !== 8'd0 || hold_ind !== 1'b0 || change_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL timeout_done: sum=%0d hold=%0b valid=%0b want 0,0,0", coin_sum, hold_ind, change_valid);
    end
  endtask

  task automatic test_reset_mid();
    coin(2'd2); coin(2'd0);
    cancel_flag = 1'b1;
    tick();
    cancel_flag = 1'b0;
    vec_cnt++;
    if (coin_sum !== 8'd6 || change_coin !== 2'd2 || charge_ind !== 1'b1) begin
      err_cnt++;
      $display("FAIL rstmid_pre: sum=%0d coin=%0d charge=%0b want 6,2,1", coin_sum, change_coin, charge_ind);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_cnt++;
    if ({hold_ind, drink_ind, coin_reject, price_short, change_valid, change_coin, charge_ind, coin_sum} !== 19'd0) begin
      err_cnt++;
      $display("FAIL rstmid_clear: got %h want 0",
               {hold_ind, drink_ind, coin_reject, price_short, change_valid, change_coin, charge_ind, coin_sum});
    end
    coin(2'd1);
    vec_cnt++;
    if (coin_sum !== 8'd2 || hold_ind !== 1'b0) begin
      err_cnt++;
      $display("FAIL rstmid_credit: sum=%0d hold=%0b want 2,0", coin_sum, hold_ind);
    end
    drain("rstmid");
  endtask

  task automatic test_back_to_back();
    coin(2'd1); coin(2'd0);
    drink_req = 1'b1; drink_op = 2'd0;
    tick();
    drink_req = 1'b0;
    vec_cnt++;
    if (drink_ind !== 4'b0001 || coin_sum !== 8'd0) begin
      err_cnt++;
      $display("FAIL exact_vend: drink=%b sum=%0d want 0001,0", drink_ind, coin_sum);
    end
    tick(); tick();
    vec_cnt++;
    if (drink_ind !== 4'd0 || hold_ind !== 1'b0 || charge_ind !== 1'b0 || change_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL exact_idle: drink=%b hold=%0b charge=%0b valid=%0b want 0,0,0,0",
               drink_ind, hold_ind, charge_ind, change_valid);
    end
    coin(2'd3);
    drink_req = 1'b1; drink_op = 2'd2;
    tick();
    drink_req = 1'b0;
    vec_cnt++;
    if (drink_ind !== 4'b0100 || coin_sum !== 8'd2) begin
      err_cnt++;
      $display("FAIL second_vend: drink=%b sum=%0d want 0100,2", drink_ind, coin_sum);
    end
    change_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    change_ready = 1'b0;
    vec_cnt++;
    if (coin_sum !== 8'd0 || hold_ind !== 1'b0) begin
      err_cnt++;
      $display("FAIL second_done: sum=%0d hold=%0b want 0,0", coin_sum, hold_ind);
    end
  endtask

  initial begin
    test_reset();
    test_vend();
    test_price_short();
    test_overflow();
    test_change_stall();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
